// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: FSM state encoding,
// RISC-V load/store funct3 codes, the "no write" byte-enable pattern and a
// helper that flags accesses not naturally aligned to their size.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dmem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] WEB_NONE = 4'hF;

  // The low two funct3 bits encode the access size for loads and stores alike.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (funct3[1:0] == F3_SH[1:0]) mis = addr_lo[0];
    else if (funct3[1:0] == F3_SW[1:0]) mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Data-memory bus between the access unit (master) and the memory (slave).
// dm_req is held with stable address/data until dm_gnt; dm_rvalid marks
// completion and, for loads, valid dm_rdata.
interface dmem_access_unit_if;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [3:0]  dm_web;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_addr, dm_web, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_addr, dm_web, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a returned memory word and sign- or
// zero-extends it according to the load funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension; unknown funct3 codes pass the word through.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data_o = rdata_i;
      F3_LBU:  data_o = {24'd0, byte_sel};
      F3_LHU:  data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns a load/store from the EX/MEM register into
// a request/grant/response bus transaction, stalling the pipeline until it
// completes and returning the extended load result.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of issuing them word-truncated.
module dmem_access_unit
  import mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               mem_wdata,
  input  logic [3:0]                mem_web,
  input  logic                      mem_write,
  input  logic                      mem_read,
  input  logic [2:0]                mem_funct3,
  dmem_access_unit_if.master        dm,
  output logic                      dm_stall,
  output logic [31:0]               load_data,
  output logic                      load_valid,
  output logic                      misalign_exc
);

  dmem_state_t state_q, state_d;
  logic [31:0] addr_q, wdata_q, load_data_q, ext_data;
  logic [3:0]  web_q;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic        start, capture, trap;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap         = is_misaligned(mem_funct3, mem_addr[1:0]);
  assign misalign_exc = (state_q == ST_DONE) && misalign_q;
  assign load_valid   = (state_q == ST_DONE) && !store_q && !misalign_q;
`else
  assign trap         = 1'b0;
  assign misalign_exc = 1'b0;
  assign load_valid   = (state_q == ST_DONE) && !store_q;
`endif

  load_extend u_load_extend (
    .rdata_i   (dm.dm_rdata),
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_q[1:0]),
    .data_o    (ext_data)
  );

  // Next-state and stall decode; bus handshakes only matter in REQ and WAIT.
  always_comb begin
    state_d  = state_q;
    dm_stall = 1'b0;
    start    = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          dm_stall = 1'b1;
          start    = 1'b1;
          state_d  = trap ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        dm_stall = 1'b1;
        if (dm.dm_gnt) begin
          if (dm.dm_rvalid) begin
            capture = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        dm_stall = 1'b1;
        if (dm.dm_rvalid) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Latch the access at acceptance (read+write together counts as a store).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      web_q      <= WEB_NONE;
      funct3_q   <= '0;
      store_q    <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else if (start) begin
      addr_q     <= mem_addr;
      wdata_q    <= mem_wdata;
      web_q      <= mem_web;
      funct3_q   <= mem_funct3;
      store_q    <= mem_write;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_q <= trap;
`endif
    end
  end

  // Load result register: updated only when a load's response is captured.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 load_data_q <= '0;
    else if (capture && !store_q) load_data_q <= ext_data;
  end

  assign load_data   = load_data_q;
  assign dm.dm_req   = (state_q == ST_REQ);
  assign dm.dm_addr  = {addr_q[31:2], 2'b00};
  assign dm.dm_web   = web_q;
  assign dm.dm_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a transaction-level expectation
// model checked every cycle plus literal checks of key results.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_web;
  logic        mem_write, mem_read;
  logic [2:0]  mem_funct3;
  logic        dm_stall, load_valid, misalign_exc;
  logic [31:0] load_data;

  dmem_access_unit_if dm_if ();

  dmem_access_unit dut (
    .clk          (clk),
    .reset        (reset),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_web      (mem_web),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_funct3   (mem_funct3),
    .dm           (dm_if),
    .dm_stall     (dm_stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .misalign_exc (misalign_exc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // expectation model state
  bit          chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_lv, exp_mis;
  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_web;
  int          lv_seen, mis_seen, stall_seen, req_seen;
  logic [31:0] last_req_addr;
  logic [3:0]  last_req_web;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Load extension from the ISA rules, with plain shifts and arithmetic.
  function automatic logic [31:0] model_ext(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] lo);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", dm_stall, exp_stall);
      check("dm_req", dm_if.dm_req, exp_req);
      check("load_valid", load_valid, exp_lv);
      check("misalign_exc", misalign_exc, exp_mis);
      check("load_data", load_data, exp_ld);
      if (exp_req) begin
        check("dm_addr", dm_if.dm_addr, exp_addr);
        check("dm_web", dm_if.dm_web, exp_web);
        check("dm_wdata", dm_if.dm_wdata, exp_wdata);
      end
      if (load_valid)   lv_seen++;
      if (misalign_exc) mis_seen++;
      if (dm_stall)     stall_seen++;
      if (dm_if.dm_req) begin
        req_seen++;
        last_req_addr = dm_if.dm_addr;
        last_req_web  = dm_if.dm_web;
      end
    end
  end

  // One complete access: req_cyc REQ cycles (gnt on the last), wait_cyc WAIT
  // cycles (rvalid on the last; 0 means rvalid together with gnt).
  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [2:0] f3,
                        input logic [3:0] web, input logic [31:0] wd, input logic [31:0] rdat,
                        input int req_cyc, input int wait_cyc, input bit trap_exp);
    bit is_load;
    is_load    = !wr;
    lv_seen    = 0;
    mis_seen   = 0;
    stall_seen = 0;
    req_seen   = 0;
    mem_addr   = a;
    mem_funct3 = f3;
    mem_web    = web;
    mem_wdata  = wd;
    mem_write  = wr;
    mem_read   = rd;
    exp_stall  = 1'b1;
    exp_req    = 1'b0;
    exp_lv     = 1'b0;
    exp_mis    = 1'b0;
    exp_addr   = a & 32'hFFFF_FFFC;
    exp_web    = web;
    exp_wdata  = wd;
    @(posedge clk); #1;
    if (!trap_exp) begin
      for (int i = 0; i < req_cyc; i++) begin
        exp_req = 1'b1;
        if (i == req_cyc - 1) begin
          dm_if.dm_gnt    = 1'b1;
          dm_if.dm_rvalid = (wait_cyc == 0);
          dm_if.dm_rdata  = rdat;
        end
        @(posedge clk); #1;
        dm_if.dm_gnt    = 1'b0;
        dm_if.dm_rvalid = 1'b0;
      end
      exp_req = 1'b0;
      for (int i = 0; i < wait_cyc; i++) begin
        if (i == wait_cyc - 1) begin
          dm_if.dm_rvalid = 1'b1;
          dm_if.dm_rdata  = rdat;
        end
        @(posedge clk); #1;
        dm_if.dm_rvalid = 1'b0;
      end
    end
    // completion cycle: upstream still shows the access, bus noise must be ignored
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    exp_lv    = is_load && !trap_exp;
    exp_mis   = trap_exp;
    if (is_load && !trap_exp) exp_ld = model_ext(rdat, f3, a[1:0]);
    dm_if.dm_gnt    = 1'b1;
    dm_if.dm_rvalid = 1'b1;
    dm_if.dm_rdata  = ~rdat;
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    exp_lv    = 1'b0;
    exp_mis   = 1'b0;
    dm_if.dm_gnt = 1'b0;
    // idle cycle with a stray response
    dm_if.dm_rvalid = 1'b1;
    @(posedge clk); #1;
    dm_if.dm_rvalid = 1'b0;
    check("lv_pulses", lv_seen, (is_load && !trap_exp) ? 1 : 0);
    check("mis_pulses", mis_seen, trap_exp ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_web = 4'hF;
    mem_write = 1'b0; mem_read = 1'b0; mem_funct3 = 3'b010;
    dm_if.dm_gnt = 1'b0; dm_if.dm_rvalid = 1'b0; dm_if.dm_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dm_req", dm_if.dm_req, 1'b0);
    check("rst_dm_addr", dm_if.dm_addr, 32'h0);
    check("rst_dm_wdata", dm_if.dm_wdata, 32'h0);
    check("rst_dm_web", dm_if.dm_web, 4'hF);
    check("rst_load_data", load_data, 32'h0);
    check("rst_load_valid", load_valid, 1'b0);
    check("rst_misalign", misalign_exc, 1'b0);
    check("rst_stall", dm_stall, 1'b0);
    reset = 1'b1;
    exp_stall = 1'b0; exp_req = 1'b0; exp_lv = 1'b0; exp_mis = 1'b0;
    exp_ld = '0; exp_addr = '0; exp_wdata = '0; exp_web = 4'hF;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // LW with delayed grant and response
    access(1'b0, 1'b1, 32'h100, 3'b010, 4'hF, 32'h0, 32'h8040_2010, 2, 3, 1'b0);
    check("lw_stall_cycles", stall_seen, 6);
    check("lw_data", load_data, 32'h8040_2010);

    // LB / LBU of the top byte
    access(1'b0, 1'b1, 32'h103, 3'b000, 4'hF, 32'h0, 32'h80FF_0000, 1, 1, 1'b0);
    check("lb_data", load_data, 32'hFFFF_FF80);
    access(1'b0, 1'b1, 32'h103, 3'b100, 4'hF, 32'h0, 32'h80FF_0000, 1, 1, 1'b0);
    check("lbu_data", load_data, 32'h0000_0080);

    // SB must not touch load_data
    access(1'b1, 1'b0, 32'h101, 3'b000, 4'b1101, 32'h0000_AB00, 32'hDEAD_BEEF, 1, 1, 1'b0);
    check("sb_addr", last_req_addr, 32'h100);
    check("sb_web", last_req_web, 4'b1101);
    check("sb_load_data", load_data, 32'h0000_0080);

    // LHU with gnt and rvalid together
    access(1'b0, 1'b1, 32'h102, 3'b101, 4'hF, 32'h0, 32'hBEEF_0000, 1, 0, 1'b0);
    check("lhu_stall_cycles", stall_seen, 2);
    check("lhu_data", load_data, 32'h0000_BEEF);

    // LH lower half, negative
    access(1'b0, 1'b1, 32'h100, 3'b001, 4'hF, 32'h0, 32'h1234_8001, 3, 1, 1'b0);
    check("lh_stall_cycles", stall_seen, 5);
    check("lh_data", load_data, 32'hFFFF_8001);

    // read and write together is a store
    access(1'b1, 1'b1, 32'h104, 3'b010, 4'h0, 32'hCAFE_F00D, 32'h1111_1111, 1, 2, 1'b0);
    check("rw_store_load_data", load_data, 32'hFFFF_8001);

    // misaligned word load
`ifdef DMEM_MISALIGN_TRAP_EN
    access(1'b0, 1'b1, 32'h102, 3'b010, 4'hF, 32'h0, 32'h5555_AAAA, 1, 1, 1'b1);
    check("mis_req_count", req_seen, 0);
    check("mis_stall_cycles", stall_seen, 1);
    check("mis_load_data", load_data, 32'hFFFF_8001);
`else
    access(1'b0, 1'b1, 32'h102, 3'b010, 4'hF, 32'h0, 32'h5555_AAAA, 1, 1, 1'b0);
    check("mis_trunc_addr", last_req_addr, 32'h100);
    check("mis_load_data", load_data, 32'h5555_AAAA);
`endif

    // reset while waiting for the response, then a late rvalid
    lv_seen = 0;
    mem_addr = 32'h108; mem_funct3 = 3'b010; mem_web = 4'hF; mem_wdata = '0;
    mem_read = 1'b1;
    exp_stall = 1'b1; exp_req = 1'b0; exp_addr = 32'h108; exp_web = 4'hF; exp_wdata = '0;
    @(posedge clk); #1;
    exp_req = 1'b1;
    dm_if.dm_gnt = 1'b1;
    @(posedge clk); #1;
    dm_if.dm_gnt = 1'b0;
    exp_req = 1'b0;
    #1;
    reset = 1'b0;
    mem_read = 1'b0;
    exp_stall = 1'b0; exp_ld = '0;
    #1;
    check("async_rst_stall", dm_stall, 1'b0);
    check("async_rst_load_data", load_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    dm_if.dm_rvalid = 1'b1;
    dm_if.dm_rdata  = 32'h7777_7777;
    @(posedge clk); #1;
    dm_if.dm_rvalid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_load_data", load_data, 32'h0);
    check("post_rst_lv_pulses", lv_seen, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
